// File: rtl/mmio_uart_tx_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// PARITY is only reachable when UART_TX_PARITY_EN is defined.
package mmio_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } tx_state_e;

    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam int   DATA_BITS       = 8;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU write-port bundle: the CPU drives we/addr/wdata, the UART block answers with en.
interface mmio_uart_tx_if;
    logic        we;
    logic [29:0] addr;
    logic [7:0]  wdata;
    logic        en;

    modport master (output we, addr, wdata, input en);
    modport slave  (input we, addr, wdata, output en);
endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// Byte FIFO between the MMIO write port and the serialiser; head is read
// combinationally so a pop can load the shift register in the same cycle.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [7:0]                    push_data,
    input  logic                          pop,
    output logic [7:0]                    pop_data,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    // Storage carries no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Depth is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr_reg];
    assign count    = count_reg;
    assign full     = (count_reg == CW'(FIFO_DEPTH));
    assign empty    = (count_reg == '0);

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: write-edge detect, address decode, byte FIFO and 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [29:0] TX_ADDR_WORD   = 30'h2c000000,
    parameter logic [29:0] CTRL_ADDR_WORD = 30'h2c000001,
    parameter int          FIFO_DEPTH     = 16,
    parameter int          CLKS_PER_BIT   = 434
) (
    input  logic                         clk,
    input  logic                         rst,
    mmio_uart_tx_if.slave                bus,
    output logic                         tx,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         overflow
);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT   = 3'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_START  = START;
    localparam logic [2:0] S_DATA   = DATA;
    localparam logic [2:0] S_STOP   = STOP;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = PARITY;
`endif

    logic          we_q_reg;
    logic          wr_edge;
    logic          tx_hit;
    logic          ctrl_hit;
    logic          push_ok;
    logic          pop;
    logic [7:0]    fifo_data;
    logic [CW-1:0] fifo_count_w;
    logic          fifo_full;
    logic          fifo_empty;
    logic          overflow_reg;

    logic [2:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_reg, bit_next;
    logic [7:0]       shift_reg, shift_next;
    logic             tx_reg, tx_next;
    logic             busy_reg, busy_next;
    logic             cnt_done;
`ifdef UART_TX_PARITY_EN
    logic             parity_reg, parity_next;
`endif

    // A held-high we yields exactly one rising edge, hence one write.
    assign wr_edge  = bus.we & ~we_q_reg;
    assign tx_hit   = wr_edge & (bus.addr == TX_ADDR_WORD);
    assign ctrl_hit = wr_edge & (bus.addr == CTRL_ADDR_WORD);
    assign push_ok  = tx_hit & (~fifo_full | pop);
    assign bus.en   = push_ok;

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_ok),
        .push_data (bus.wdata),
        .pop       (pop),
        .pop_data  (fifo_data),
        .count     (fifo_count_w),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign cnt_done = (cnt_reg == '0);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_done ? cnt_reg : cnt_reg - 1'b1;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_data;
`ifdef UART_TX_PARITY_EN
                    parity_next = even_parity(fifo_data);
`endif
                    state_next = S_START;
                    cnt_next   = CNT_RELOAD;
                end
            end
            S_START: begin
                if (cnt_done) begin
                    state_next = S_DATA;
                    cnt_next   = CNT_RELOAD;
                    bit_next   = '0;
                end
            end
            S_DATA: begin
                if (cnt_done) begin
                    cnt_next   = CNT_RELOAD;
                    shift_next = {1'b0, shift_reg[7:1]};
                    bit_next   = bit_reg + 3'd1;
                    if (bit_reg == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (cnt_done) begin
                    state_next = S_STOP;
                    cnt_next   = CNT_RELOAD;
                end
            end
`endif
            S_STOP: begin
                if (cnt_done) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // The pin level is derived from the next state and registered, so tx never glitches.
    always_comb begin
        tx_next = UART_IDLE_LEVEL;
        case (state_next)
            S_START:  tx_next = ~UART_IDLE_LEVEL;
            S_DATA:   tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_next = parity_next;
`endif
            default:  tx_next = UART_IDLE_LEVEL;
        endcase
        busy_next = (state_next != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q_reg     <= 1'b0;
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            bit_reg      <= '0;
            shift_reg    <= '0;
            tx_reg       <= UART_IDLE_LEVEL;
            busy_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            we_q_reg  <= bus.we;
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
            busy_reg  <= busy_next;
            // A dropped byte outranks a simultaneous clear.
            if (tx_hit && !push_ok) begin
                overflow_reg <= 1'b1;
            end else if (ctrl_hit) begin
                overflow_reg <= 1'b0;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_reg <= 1'b0;
        end else begin
            parity_reg <= parity_next;
        end
    end
`endif

    assign tx         = tx_reg;
    assign busy       = busy_reg;
    assign fifo_count = fifo_count_w;
    assign overflow   = overflow_reg;

endmodule
